// File: rtl/rot_shift_pipe_pkg.sv
// -----------------------------------------------------------------------------
// rot_shift_pkg
// Shared types for the pipelined rotator/shifter.
//   rs_mode_t  : operating mode carried with every beat through the pipeline.
//   rs_ctrl_t  : width-independent part of a stage payload (valid + mode).
//                The top module wraps it with WIDTH-dependent amount/data
//                fields to form the full stage register.
// -----------------------------------------------------------------------------
package rot_shift_pkg;

  localparam int RS_MODE_W = 2;

  typedef enum logic [RS_MODE_W-1:0] {
    RS_ROR = 2'd0,
    RS_ROL = 2'd1,
    RS_LSR = 2'd2,
    RS_ASR = 2'd3
  } rs_mode_t;

  typedef struct packed {
    logic     valid;
    rs_mode_t mode;
  } rs_ctrl_t;

endpackage : rot_shift_pkg

// File: rtl/rot_shift_pipe_if.sv
// -----------------------------------------------------------------------------
// rot_shift_pipe_if
// Stream interface of the rotator/shifter.
//   in_valid/in_ready/in_data/in_amt/in_mode : producer side beat
//   out_valid/out_ready/out_data             : consumer side beat
//   busy                                     : any pipeline stage occupied
// Modports:
//   slave  : view of the rot_shift_pipe block
//   master : view of the environment driving/consuming the block
// -----------------------------------------------------------------------------
interface rot_shift_pipe_if #(
  parameter int WIDTH = 8
);

  localparam int AW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_amt,
    input  in_mode,
    output out_valid,
    input  out_ready,
    output out_data,
    output busy
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_amt,
    output in_mode,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  busy
  );

endinterface : rot_shift_pipe_if

// File: rtl/rot_shift_pipe_stage.sv
// -----------------------------------------------------------------------------
// rot_shift_stage
// Purely combinational single-stage move of SHIFT bits (SHIFT = 2^k).
//   en    : amount bit k of the beat; 0 passes the data through unchanged
//   mode  : ROR / ROL / LSR / ASR
//   d_in  : data entering the stage
//   d_out : moved data, registered by the top module
// SHIFT is always in 1..WIDTH/2, so every slice below is non-empty.
// -----------------------------------------------------------------------------
module rot_shift_stage
  import rot_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1
) (
  input  logic             en,
  input  rs_mode_t         mode,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  // Select the moved word for this stage, or pass through when not enabled.
  always_comb begin
    d_out = d_in;
    if (en) begin
      case (mode)
        RS_ROR:  d_out = {d_in[SHIFT-1:0], d_in[WIDTH-1:SHIFT]};
        RS_ROL:  d_out = {d_in[WIDTH-1-SHIFT:0], d_in[WIDTH-1:WIDTH-SHIFT]};
        RS_LSR:  d_out = {{SHIFT{1'b0}}, d_in[WIDTH-1:SHIFT]};
        // The MSB seen here is still the original sign: earlier stages only
        // ever refill the top with that same bit.
        RS_ASR:  d_out = {{SHIFT{d_in[WIDTH-1]}}, d_in[WIDTH-1:SHIFT]};
        default: d_out = d_in;
      endcase
    end else begin
      d_out = d_in;
    end
  end

endmodule : rot_shift_stage

// File: rtl/rot_shift_pipe.sv
// -----------------------------------------------------------------------------
// rot_shift_pipe
// Pipelined barrel rotator/shifter with a valid/ready stream interface.
// WIDTH must be a power of two, at least 4; the pipeline has AW=log2(WIDTH)
// register stages, stage k moving by 2^k when amount bit k is set.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, flushes every in-flight beat
//   bus : rot_shift_pipe_if.slave (in_* beat, out_* beat, busy)
// Flow control is a single global advance: the whole pipe moves when the
// output slot is empty or being taken, otherwise every stage holds. Bubbles
// travel like beats, so latency is a fixed AW cycles when unstalled.
// -----------------------------------------------------------------------------
module rot_shift_pipe
  import rot_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  rot_shift_pipe_if.slave bus
);

  localparam int AW = $clog2(WIDTH);

  typedef struct packed {
    rs_ctrl_t         ctrl;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t           stage_r  [AW];
  stage_t           src_s    [AW];
  stage_t           nxt_s    [AW];
  logic [WIDTH-1:0] moved_s  [AW];
  stage_t           head_s;
  logic             adv_s;
  logic             in_ready_s;
  logic             in_fire_s;
  logic             busy_s;

  // The last stage is the output register, so it gates the whole pipeline.
  assign adv_s      = !stage_r[AW-1].ctrl.valid || bus.out_ready;
  assign in_ready_s = adv_s && !rst;
  assign in_fire_s  = bus.in_valid && in_ready_s;

  // Payload entering stage 0; valid only for an actual transfer.
  always_comb begin
    head_s           = '0;
    head_s.ctrl.valid = in_fire_s;
    head_s.ctrl.mode  = rs_mode_t'(bus.in_mode);
    head_s.amt        = bus.in_amt;
    head_s.data       = bus.in_data;
  end

  for (genvar k = 0; k < AW; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_s[k] = head_s;
    end else begin : g_body
      assign src_s[k] = stage_r[k-1];
    end

    rot_shift_stage #(
      .WIDTH (WIDTH),
      .SHIFT (2 ** k)
    ) u_stage (
      .en    (src_s[k].amt[k]),
      .mode  (src_s[k].ctrl.mode),
      .d_in  (src_s[k].data),
      .d_out (moved_s[k])
    );

    // Control and amount ride along unchanged; only the data is moved.
    assign nxt_s[k] = {src_s[k].ctrl, src_s[k].amt, moved_s[k]};
  end

  // Stage registers: flush on reset, load on advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < AW; k++) begin
        stage_r[k] <= '0;
      end
    end else if (adv_s) begin
      for (int k = 0; k < AW; k++) begin
        stage_r[k] <= nxt_s[k];
      end
    end else begin
      for (int k = 0; k < AW; k++) begin
        stage_r[k] <= stage_r[k];
      end
    end
  end

  // Occupancy: OR of every stage valid bit.
  always_comb begin
    busy_s = 1'b0;
    for (int k = 0; k < AW; k++) begin
      busy_s = busy_s | stage_r[k].ctrl.valid;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = stage_r[AW-1].ctrl.valid;
  assign bus.out_data  = stage_r[AW-1].data;
  assign bus.busy      = busy_s;

endmodule : rot_shift_pipe

// File: tb/tb_rot_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_rot_shift_pipe
// Self-checking bench for rot_shift_pipe (WIDTH=8). Inputs are driven 1 ns
// after the rising edge; handshakes and outputs are sampled on the falling
// edge. Expected results are queued on input transfer and popped on output
// transfer; directed tests queue literal results, the random test queues the
// output of an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_rot_shift_pipe;

  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rot_shift_pipe_if #(.WIDTH(WIDTH)) bus ();

  rot_shift_pipe #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [WIDTH-1:0] exp_q [$];
  int               acc_q [$];
  logic [WIDTH-1:0] next_exp;
  bit               lat_chk;
  bit               in_fire_g;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Reference: rotate via a doubled word, shifts via native operators.
  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] d, input int a, input int m);
    logic [2*WIDTH-1:0]      dd;
    logic [2*WIDTH-1:0]      t;
    logic signed [WIDTH-1:0] s;
    dd = {d, d};
    case (m)
      0: begin t = dd >> a; return t[WIDTH-1:0]; end
      1: begin t = dd << a; return t[2*WIDTH-1:WIDTH]; end
      2: return d >> a;
      default: begin s = d; s = s >>> a; return s; end
    endcase
  endfunction

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input int a, input int m,
                       input logic [WIDTH-1:0] e);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_amt   = 3'(a);
    bus.in_mode  = 2'(m);
    next_exp     = e;
  endtask

  // One clock cycle: sample at negedge, score, advance past the rising edge.
  task automatic cycle();
    bit               out_fire;
    bit               flush;
    logic [WIDTH-1:0] e;
    int               a;
    @(negedge clk);
    in_fire_g = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
    out_fire  = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        check_val("out_valid_unexpected", bus.out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check_val("out_data", bus.out_data, e);
        if (lat_chk) check_val("latency", cyc - a, AW);
      end
    end
    if (in_fire_g) begin
      exp_q.push_back(next_exp);
      acc_q.push_back(cyc);
    end
    flush = (rst === 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    if (flush) begin
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 0, 0, '0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [WIDTH-1:0] t1_exp [4] = '{8'hD2, 8'hB4, 8'h12, 8'hF2};
  logic [WIDTH-1:0] t2_dat [6] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h01, 8'h80};
  int               t2_amt [6] = '{0, 0, 0, 0, 7, 7};
  int               t2_mod [6] = '{0, 1, 2, 3, 0, 3};
  logic [WIDTH-1:0] t2_exp [6] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h02, 8'hFF};

  initial begin
    int               k;
    int               accepted;
    logic [WIDTH-1:0] d;
    int               a;
    int               m;

    rst           = 1'b1;
    bus.out_ready = 1'b1;
    lat_chk       = 1'b1;
    drive(1'b0, '0, 0, 0, '0);

    // Reset state
    cycle();
    cycle();
    check_val("rst_in_ready", bus.in_ready, 0);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_data", bus.out_data, 0);
    check_val("rst_busy", bus.busy, 0);
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", bus.in_ready, 1);

    // Test 1: 0x96 by 3 in every mode
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h96, 3, i, t1_exp[i]);
      cycle();
    end
    idle(6);

    // Test 2: zero amount and extreme amounts
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, t2_dat[i], t2_amt[i], t2_mod[i], t2_exp[i]);
      cycle();
    end
    idle(6);

    // Test 3: back-to-back stream, ROL by 1
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 1, 1, 8'(2 * i));
      check_val("stream_in_ready", bus.in_ready, 1);
      cycle();
    end
    idle(6);

    // Test 4: fill with consumer stalled, hold 5 cycles, then drain
    lat_chk       = 1'b0;
    bus.out_ready = 1'b0;
    k = 0;
    for (int n = 0; n < 10 && k < 3; n++) begin
      drive(1'b1, 8'(8'h10 + k), 1, 1, 8'(2 * (8'h10 + k)));
      cycle();
      if (in_fire_g) k++;
    end
    check_val("fill_count", k, 3);
    drive(1'b1, 8'h13, 1, 1, 8'h26);
    for (int i = 0; i < 5; i++) begin
      check_val("stall_in_ready", bus.in_ready, 0);
      check_val("stall_out_valid", bus.out_valid, 1);
      check_val("stall_out_data", bus.out_data, 8'h20);
      check_val("stall_busy", bus.busy, 1);
      cycle();
    end
    bus.out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (in_fire_g) break;
    end
    idle(8);
    check_val("stall_drain_empty", exp_q.size(), 0);

    // Test 5: reset with three beats in flight
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h31 + i), 2, 0, ref_op(8'(8'h31 + i), 2, 0));
      cycle();
    end
    rst = 1'b1;
    drive(1'b1, 8'hFF, 1, 2, 8'h7F);
    #1;
    check_val("mid_rst_in_ready", bus.in_ready, 0);
    cycle();
    rst = 1'b0;
    check_val("mid_rst_out_valid", bus.out_valid, 0);
    check_val("mid_rst_out_data", bus.out_data, 0);
    check_val("mid_rst_busy", bus.busy, 0);
    drive(1'b1, 8'hC3, 5, 1, 8'h78);
    cycle();
    idle(6);
    check_val("mid_rst_drain_empty", exp_q.size(), 0);

    // Test 6: random stream with producer and consumer gaps
    lat_chk  = 1'b0;
    accepted = 0;
    for (int n = 0; n < 60000 && accepted < 10000; n++) begin
      d = 8'($urandom);
      a = int'($urandom_range(0, 7));
      m = int'($urandom_range(0, 3));
      drive($urandom_range(0, 99) < 70, d, a, m, ref_op(d, a, m));
      bus.out_ready = ($urandom_range(0, 99) < 70);
      cycle();
      if (in_fire_g) accepted++;
    end
    check_val("random_accepted", accepted, 10000);
    bus.out_ready = 1'b1;
    idle(10);
    check_val("random_drain_empty", exp_q.size(), 0);
    check_val("random_drain_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rot_shift_pipe
